// File: rtl/line_mem_pkg.sv
// Shared types and constants for the line memory responder.
package line_mem_pkg;
  typedef logic [127:0] line_t;
  typedef logic [35:0]  word_addr_t;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_e;

  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_W         = 32;
  localparam int CNT_W          = 4;
endpackage

// File: rtl/line_mem_if.sv
// Cache line request/response channel between a requester and the line memory.
interface line_mem_if;
  import line_mem_pkg::*;

  // Both channels use valid/ready: a beat transfers on a rising edge where
  // valid && ready; a sender holds valid and its payload stable until then.
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  word_addr_t                req_addr;
  line_t                     req_data;
  logic [WORDS_PER_LINE-1:0] req_mask;
  logic                      resp_valid;
  logic                      resp_ready;
  logic                      resp_we;
  line_t                     resp_data;
  logic                      resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_data, req_mask, resp_ready,
    input  req_ready, resp_valid, resp_we, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_data, req_mask, resp_ready,
    output req_ready, resp_valid, resp_we, resp_data, resp_err
  );
endinterface

// File: rtl/line_ram.sv
// Single-port DEPTH x 128-bit line storage with per-word write enable and registered read.
module line_ram
  import line_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic [AW-1:0]             addr,
  input  logic [WORDS_PER_LINE-1:0] wr_en,
  input  line_t                     wr_data,
  input  logic                      rd_en,
  output line_t                     rd_data
);
  line_t mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WORDS_PER_LINE; i++) begin
      if (wr_en[i]) mem[addr][i*WORD_W +: WORD_W] <= wr_data[i*WORD_W +: WORD_W];
    end
    if (rd_en) rd_data <= mem[addr];
  end
endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency backing memory for cache line fills and write-backs.
// Optional per-word write masking is enabled by defining LINE_RESP_WORD_MASK_EN.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  line_mem_if.slave   bus,
  output resp_state_e dbg_state
);
  localparam int AW = $clog2(DEPTH);
  // WAIT lasts LATENCY-1 cycles, so the counter loads LATENCY-2 and exits at zero.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  resp_state_e               state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      accept;
  logic                      in_range;
  logic                      rd_en;
  logic [WORDS_PER_LINE-1:0] wr_en;
  logic [AW-1:0]             line_idx;
  line_t                     rd_data;
  logic                      resp_we_q;
  logic                      resp_err_q;
  logic                      data_sel_q;
  logic                      unused_bits;

  assign line_idx = bus.req_addr[2 +: AW];
  assign in_range = (bus.req_addr >> (2 + AW)) == '0;
  assign accept   = bus.req_valid && (state_q == IDLE) && !rst;
  assign rd_en    = accept && !bus.req_we && in_range;

`ifdef LINE_RESP_WORD_MASK_EN
  assign wr_en       = (accept && bus.req_we && in_range) ? bus.req_mask : '0;
  assign unused_bits = ^bus.req_addr[1:0];
`else
  assign wr_en       = {WORDS_PER_LINE{accept && bus.req_we && in_range}};
  assign unused_bits = ^{bus.req_addr[1:0], bus.req_mask};
`endif

  line_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .addr    (line_idx),
    .wr_en   (wr_en),
    .wr_data (bus.req_data),
    .rd_en   (rd_en),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY <= 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data lives in the RAM output register; data_sel_q zeroes it for writes and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_we_q  <= 1'b0;
      resp_err_q <= 1'b0;
      data_sel_q <= 1'b0;
    end else if (accept) begin
      resp_we_q  <= bus.req_we;
      resp_err_q <= !in_range;
      data_sel_q <= !bus.req_we && in_range;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_we    = resp_we_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_data  = data_sel_q ? rd_data : '0;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// Directed, table-driven bench for line_mem_responder (LATENCY=4 main instance, LATENCY=1 corner instance).
`timescale 1ns/1ps
module tb_line_mem_responder;
  import line_mem_pkg::*;

  localparam int LATENCY = 4;
  localparam line_t D0 = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam line_t D1 = 128'h00000004_00000003_00000002_00000001;
  localparam line_t D2 = 128'hcafef00d_5a5a5a5a_a5a5a5a5_0badc0de;
  localparam line_t D3 = 128'h11111111_22222222_33333333_44444444;
  localparam line_t ONES = {128{1'b1}};
`ifdef LINE_RESP_WORD_MASK_EN
  localparam line_t EXP_MASKED = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;
  localparam line_t EXP_NOOP   = D1;
`else
  localparam line_t EXP_MASKED = '0;
  localparam line_t EXP_NOOP   = D3;
`endif

  typedef struct {
    logic       we;
    word_addr_t addr;
    line_t      data;
    logic [3:0] mask;
    int         hold;
    logic       chk_data;
    logic       exp_err;
    line_t      exp_data;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_mem_if  bus();
  line_mem_if  bus1();
  resp_state_e dbg_state, dbg_state1;

  line_mem_responder #(.DEPTH(1024), .LATENCY(LATENCY)) u_dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );
  line_mem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dbg_state(dbg_state1)
  );

  // scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [127:0] exp_q[$];
  vec_t        vecs[$];
  int          lat;
  logic        gw, ge, saw;
  line_t       gd, exp_d;

  task automatic check_bit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input line_t act, input line_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input word_addr_t addr, input line_t data,
                              input logic [3:0] mask, input int hold, input logic chk,
                              input logic err, input line_t exp);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.mask = mask; v.hold = hold;
    v.chk_data = chk; v.exp_err = err; v.exp_data = exp;
    return v;
  endfunction

  // driver: one full request/response transaction on the main instance
  task automatic send(input vec_t v, output int lat_o, output logic we_o,
                      output logic err_o, output line_t data_o);
    check_bit("pre_req_ready", bus.req_ready, 1'b1);
    bus.req_valid  = 1'b1;
    bus.req_we     = v.we;
    bus.req_addr   = v.addr;
    bus.req_data   = v.data;
    bus.req_mask   = v.mask;
    bus.resp_ready = (v.hold == 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat_o = 1;
    while (!bus.resp_valid && lat_o < 40) begin
      @(posedge clk); #1;
      lat_o++;
    end
    we_o   = bus.resp_we;
    err_o  = bus.resp_err;
    data_o = bus.resp_data;
    if (!bus.resp_valid) begin
      check_bit("resp_timeout", bus.resp_valid, 1'b1);
      return;
    end
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk); #1;
      check_bit("hold_valid", bus.resp_valid, 1'b1);
      check_line("hold_data", bus.resp_data, data_o);
      check_bit("hold_req_ready", bus.req_ready, 1'b0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    check_bit("done_valid", bus.resp_valid, 1'b0);
    check_bit("done_req_ready", bus.req_ready, 1'b1);
  endtask

  initial begin
    bus.req_valid = 1'b0;  bus.req_we = 1'b0;  bus.req_addr = '0;
    bus.req_data  = '0;    bus.req_mask = '0;  bus.resp_ready = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_addr = '0;
    bus1.req_data  = '0;   bus1.req_mask = '0; bus1.resp_ready = 1'b0;

    vecs.push_back(mk(1'b0, 36'h0,         '0,   4'hf, 0,  1'b0, 1'b0, '0));
    vecs.push_back(mk(1'b1, 36'h40,        D1,   4'hf, 0,  1'b1, 1'b0, '0));
    vecs.push_back(mk(1'b0, 36'h40,        '0,   4'hf, 10, 1'b1, 1'b0, D1));
    vecs.push_back(mk(1'b1, 36'h0,         D0,   4'hf, 0,  1'b1, 1'b0, '0));
    vecs.push_back(mk(1'b0, 36'h0,         '0,   4'hf, 0,  1'b1, 1'b0, D0));
    vecs.push_back(mk(1'b1, 36'h80,        ONES, 4'hf, 0,  1'b1, 1'b0, '0));
    vecs.push_back(mk(1'b1, 36'h80,        '0,   4'h5, 0,  1'b1, 1'b0, '0));
    vecs.push_back(mk(1'b0, 36'h80,        '0,   4'hf, 0,  1'b1, 1'b0, EXP_MASKED));
    vecs.push_back(mk(1'b0, 36'h1000,      '0,   4'hf, 0,  1'b1, 1'b1, '0));
    vecs.push_back(mk(1'b1, 36'h1000,      D2,   4'hf, 0,  1'b1, 1'b1, '0));
    vecs.push_back(mk(1'b0, 36'h0,         '0,   4'hf, 2,  1'b1, 1'b0, D0));
    vecs.push_back(mk(1'b0, 36'h43,        '0,   4'hf, 0,  1'b1, 1'b0, D1));
    vecs.push_back(mk(1'b1, 36'hffc,       D2,   4'hf, 0,  1'b1, 1'b0, '0));
    vecs.push_back(mk(1'b0, 36'hffc,       '0,   4'hf, 0,  1'b1, 1'b0, D2));
    vecs.push_back(mk(1'b0, 36'h8_0000_0000, '0, 4'hf, 0,  1'b1, 1'b1, '0));
    vecs.push_back(mk(1'b1, 36'h40,        D3,   4'h0, 0,  1'b1, 1'b0, '0));
    vecs.push_back(mk(1'b0, 36'h40,        '0,   4'hf, 0,  1'b1, 1'b0, EXP_NOOP));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    check_bit("rst_req_ready", bus.req_ready, 1'b1);
    check_bit("rst_resp_valid", bus.resp_valid, 1'b0);
    check_bit("rst_resp_we", bus.resp_we, 1'b0);
    check_bit("rst_resp_err", bus.resp_err, 1'b0);
    check_line("rst_resp_data", bus.resp_data, '0);
    check_bit("rst_state_idle", dbg_state == IDLE, 1'b1);
    check_bit("rst_req_ready_l1", bus1.req_ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      exp_q.push_back(vecs[i].exp_data);
      send(vecs[i], lat, gw, ge, gd);
      exp_d = exp_q.pop_front();
      check_int($sformatf("v%0d_latency", i), lat, LATENCY);
      check_bit($sformatf("v%0d_resp_we", i), gw, vecs[i].we);
      check_bit($sformatf("v%0d_resp_err", i), ge, vecs[i].exp_err);
      if (vecs[i].chk_data) check_line($sformatf("v%0d_resp_data", i), gd, exp_d);
    end

    // reset pulse in the middle of WAIT drops the pending read
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 36'h0; bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check_bit("rstwait_in_wait", dbg_state == WAIT, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_bit("rstwait_req_ready", bus.req_ready, 1'b1);
    saw = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      saw = saw | bus.resp_valid;
    end
    check_bit("rstwait_no_resp", saw, 1'b0);
    bus.resp_ready = 1'b0;

    // request presented together with reset must not be accepted or committed
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 36'h40;
    bus.req_data = D2; bus.req_mask = 4'hf;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 1'b0;
    check_bit("rstreq_req_ready", bus.req_ready, 1'b1);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      saw = saw | bus.resp_valid;
    end
    check_bit("rstreq_no_resp", saw, 1'b0);
    send(mk(1'b0, 36'h40, '0, 4'hf, 0, 1'b1, 1'b0, EXP_NOOP), lat, gw, ge, gd);
    check_line("rstreq_line_kept", gd, EXP_NOOP);

    // LATENCY=1, DEPTH=16 instance
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_addr = 36'h4;
    bus1.req_data = D0; bus1.req_mask = 4'hf; bus1.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    check_bit("l1_wr_valid", bus1.resp_valid, 1'b1);
    check_bit("l1_wr_we", bus1.resp_we, 1'b1);
    check_bit("l1_wr_req_ready", bus1.req_ready, 1'b0);
    @(posedge clk); #1;
    check_bit("l1_wr_done", bus1.resp_valid, 1'b0);
    check_bit("l1_wr_ready_back", bus1.req_ready, 1'b1);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.resp_ready = 1'b0;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    check_bit("l1_rd_valid", bus1.resp_valid, 1'b1);
    check_line("l1_rd_data", bus1.resp_data, D0);
    bus1.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.req_valid = 1'b1; bus1.req_addr = 36'h40;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    check_bit("l1_oor_err", bus1.resp_err, 1'b1);
    check_line("l1_oor_data", bus1.resp_data, '0);
    @(posedge clk); #1;
    check_bit("l1_oor_done", bus1.resp_valid, 1'b0);
    bus1.resp_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
